// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and defaults for the PLL reset sequencer and its synchroniser.
package pll_reset_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_HOLD      = 2'd1,
    ST_RELEASE   = 2'd2,
    ST_RUN       = 2'd3
  } pll_state_e;

  localparam int unsigned SYNC_STAGES_DEFAULT = 2;
  localparam int unsigned LOCK_HOLD_DEFAULT   = 1024;
  localparam int unsigned STAGE_GAP_DEFAULT   = 16;
  localparam int unsigned LOSS_CNT_W_DEFAULT  = 16;

  // States in which the core is out of reset; a lock drop here is a real loss.
  function automatic logic is_released(input pll_state_e s);
    return (s == ST_RELEASE) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_bit.sv
// sync_bit: parameterised-depth single-bit synchroniser for asynchronous flags.
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Staged reset release after stable PLL lock, with lock-loss detection.
// Optional loss counter enabled by defining PLL_RESET_LOSS_COUNTER_EN.
module pll_reset_sequencer
  import pll_reset_sequencer_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter int unsigned LOCK_HOLD   = LOCK_HOLD_DEFAULT,
  parameter int unsigned STAGE_GAP   = STAGE_GAP_DEFAULT,
  parameter int unsigned LOSS_CNT_W  = LOSS_CNT_W_DEFAULT
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  PLL_LOCKED,
  input  logic                  SW_RESET,
  output logic                  RST_CORE,
  output logic                  RST_READOUT,
  output logic                  READY,
  output logic [1:0]            STATE,
  output logic [LOSS_CNT_W-1:0] LOSS_COUNT,
  output logic                  LOSS_PULSE
);

  localparam int unsigned HOLD_W = $clog2(LOCK_HOLD);
  localparam int unsigned GAP_W  = $clog2(STAGE_GAP + 1);

  logic              w_locked_s;
  pll_state_e        r_state;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic              r_rst_core;
  logic              r_rst_readout;
  logic              r_ready;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .i_clk (CLK),
    .i_rst (RESET),
    .i_d   (PLL_LOCKED),
    .o_q   (w_locked_s)
  );

  // Sequencing FSM; reset outputs only go low on entry to RELEASE/RUN.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state       <= ST_WAIT_LOCK;
      r_hold_cnt    <= '0;
      r_gap_cnt     <= '0;
      r_rst_core    <= 1'b1;
      r_rst_readout <= 1'b1;
      r_ready       <= 1'b0;
    end else begin
      case (r_state)
        ST_WAIT_LOCK: begin
          r_rst_core    <= 1'b1;
          r_rst_readout <= 1'b1;
          r_ready       <= 1'b0;
          if (w_locked_s) begin
            r_state    <= ST_HOLD;
            r_hold_cnt <= '0;
          end
        end

        ST_HOLD: begin
          r_rst_core    <= 1'b1;
          r_rst_readout <= 1'b1;
          r_ready       <= 1'b0;
          if (!w_locked_s) begin
            r_state <= ST_WAIT_LOCK;
          end else if (SW_RESET) begin
            r_hold_cnt <= '0;
          end else if (r_hold_cnt == HOLD_W'(LOCK_HOLD - 1)) begin
            r_state    <= ST_RELEASE;
            r_gap_cnt  <= '0;
            r_rst_core <= 1'b0;
          end else begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
          end
        end

        ST_RELEASE: begin
          if (!w_locked_s) begin
            r_state       <= ST_WAIT_LOCK;
            r_rst_core    <= 1'b1;
            r_rst_readout <= 1'b1;
          end else if (SW_RESET) begin
            r_state       <= ST_HOLD;
            r_hold_cnt    <= '0;
            r_rst_core    <= 1'b1;
            r_rst_readout <= 1'b1;
          end else if (r_gap_cnt == GAP_W'(STAGE_GAP - 1)) begin
            r_state       <= ST_RUN;
            r_rst_readout <= 1'b0;
            r_ready       <= 1'b1;
          end else begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
          end
        end

        ST_RUN: begin
          if (!w_locked_s) begin
            r_state       <= ST_WAIT_LOCK;
            r_rst_core    <= 1'b1;
            r_rst_readout <= 1'b1;
            r_ready       <= 1'b0;
          end else if (SW_RESET) begin
            r_state       <= ST_HOLD;
            r_hold_cnt    <= '0;
            r_rst_core    <= 1'b1;
            r_rst_readout <= 1'b1;
            r_ready       <= 1'b0;
          end
        end

        default: begin
          r_state       <= ST_WAIT_LOCK;
          r_rst_core    <= 1'b1;
          r_rst_readout <= 1'b1;
          r_ready       <= 1'b0;
        end
      endcase
    end
  end

`ifdef PLL_RESET_LOSS_COUNTER_EN
  logic                  w_lock_lost;
  logic [LOSS_CNT_W-1:0] r_loss_count;
  logic                  r_loss_pulse;

  // A loss is a lock drop seen while released; it overrides any SW_RESET.
  assign w_lock_lost = is_released(r_state) && !w_locked_s;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_loss_count <= '0;
      r_loss_pulse <= 1'b0;
    end else begin
      r_loss_pulse <= w_lock_lost;
      if (w_lock_lost && !(&r_loss_count)) begin
        r_loss_count <= r_loss_count + LOSS_CNT_W'(1);
      end
    end
  end

  assign LOSS_COUNT = r_loss_count;
  assign LOSS_PULSE = r_loss_pulse;
`else
  assign LOSS_COUNT = '0;
  assign LOSS_PULSE = 1'b0;
`endif

  assign RST_CORE    = r_rst_core;
  assign RST_READOUT = r_rst_readout;
  assign READY       = r_ready;
  assign STATE       = 2'(r_state);

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed test-plan steps plus random lock/SW_RESET traffic
// checked every cycle against an elapsed-time model of the sequencing rules.
module tb_pll_reset_sequencer;

  localparam int unsigned S  = 2;
  localparam int unsigned LH = 8;
  localparam int unsigned SG = 4;
  localparam int unsigned CW = 4;
  localparam int unsigned CNT_MAX = (1 << CW) - 1;
`ifdef PLL_RESET_LOSS_COUNTER_EN
  localparam int unsigned CNT_EN = 1;
`else
  localparam int unsigned CNT_EN = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          pll_locked;
  logic          sw_reset;
  logic          rst_core;
  logic          rst_readout;
  logic          ready;
  logic [1:0]    state;
  logic [CW-1:0] loss_count;
  logic          loss_pulse;

  int total = 0;
  int bad   = 0;

  // Model: lock delay line, whether a qualified lock is in progress, and the
  // edge at which the current hold window started.
  bit          m_dly[S];
  bit          m_active = 1'b0;
  int          m_t0 = 0;
  int          m_n  = 0;
  int unsigned m_cnt = 0;
  bit          m_pulse = 1'b0;

  pll_reset_sequencer #(
    .SYNC_STAGES (S),
    .LOCK_HOLD   (LH),
    .STAGE_GAP   (SG),
    .LOSS_CNT_W  (CW)
  ) dut (
    .CLK         (clk),
    .RESET       (rst),
    .PLL_LOCKED  (pll_locked),
    .SW_RESET    (sw_reset),
    .RST_CORE    (rst_core),
    .RST_READOUT (rst_readout),
    .READY       (ready),
    .STATE       (state),
    .LOSS_COUNT  (loss_count),
    .LOSS_PULSE  (loss_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit lk_in, input bit sw, input bit rs);
    bit lk;
    int e;
    lk = m_dly[S-1];
    if (rs) begin
      for (int i = 0; i < int'(S); i++) m_dly[i] = 1'b0;
      m_active = 1'b0;
      m_cnt    = 0;
      m_pulse  = 1'b0;
    end else begin
      for (int i = int'(S) - 1; i > 0; i--) m_dly[i] = m_dly[i-1];
      m_dly[0] = lk_in;
      m_pulse  = 1'b0;
      if (!m_active) begin
        if (lk) begin
          m_active = 1'b1;
          m_t0     = m_n;
        end
      end else begin
        e = m_n - m_t0;
        if (!lk) begin
          if (e > int'(LH)) begin
            m_pulse = 1'b1;
            if (m_cnt < CNT_MAX) m_cnt++;
          end
          m_active = 1'b0;
        end else if (sw) begin
          m_t0 = m_n;
        end
      end
    end
    m_n++;
  endtask

  task automatic check_all();
    int e;
    int exp_st;
    e = m_n - m_t0;
    if (!m_active)                exp_st = 0;
    else if (e <= int'(LH))       exp_st = 1;
    else if (e <= int'(LH + SG))  exp_st = 2;
    else                          exp_st = 3;
    chk("state",       32'(state),       32'(exp_st));
    chk("rst_core",    32'(rst_core),    32'(exp_st < 2));
    chk("rst_readout", 32'(rst_readout), 32'(exp_st < 3));
    chk("ready",       32'(ready),       32'(exp_st == 3));
    chk("loss_count",  32'(loss_count),  32'(CNT_EN * m_cnt));
    chk("loss_pulse",  32'(loss_pulse),  32'(CNT_EN * 32'(m_pulse)));
  endtask

  task automatic step(input bit lk, input bit sw, input bit rs);
    pll_locked = lk;
    sw_reset   = sw;
    rst        = rs;
    @(posedge clk);
    model_edge(lk, sw, rs);
    #1;
    check_all();
  endtask

  task automatic run(input bit lk, input int n);
    for (int i = 0; i < n; i++) step(lk, 1'b0, 1'b0);
  endtask

  initial begin
    int  npulse;
    bit  lk_r;
    pll_locked = 1'b0;
    sw_reset   = 1'b0;
    rst        = 1'b1;

    // Power-up: RESET on edges 0..3, lock first sampled at edge 10.
    for (int e = 0; e <= 30; e++) begin
      step(e >= 10, 1'b0, e <= 3);
      if (e == 3)  chk("pu_reset_core", 32'(rst_core), 32'd1);
      if (e == 11) chk("pu_wait", 32'(state), 32'd0);
      if (e == 12) chk("pu_hold", 32'(state), 32'd1);
      if (e == 19) chk("pu_core_hi", 32'(rst_core), 32'd1);
      if (e == 20) chk("pu_core_lo", 32'(rst_core), 32'd0);
      if (e == 23) chk("pu_ready_lo", 32'(ready), 32'd0);
      if (e == 24) begin
        chk("pu_ready_hi", 32'(ready), 32'd1);
        chk("pu_ro_lo", 32'(rst_readout), 32'd0);
      end
    end

    // Loss in RUN.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (i == 1) chk("loss_still_run", 32'(state), 32'd3);
      if (i == 2) begin
        chk("loss_wait", 32'(state), 32'd0);
        chk("loss_core_hi", 32'(rst_core), 32'd1);
        chk("loss_pulse_on", 32'(loss_pulse), 32'(CNT_EN));
        chk("loss_count1", 32'(loss_count), 32'(CNT_EN));
      end
      if (i == 3) chk("loss_pulse_off", 32'(loss_pulse), 32'd0);
    end

    // Glitchy lock: short high does not complete the hold and is not a loss.
    run(1'b1, 5);
    chk("glitch_hold", 32'(state), 32'd1);
    run(1'b0, 3);
    chk("glitch_wait", 32'(state), 32'd0);
    chk("glitch_count", 32'(loss_count), 32'(CNT_EN));
    run(1'b1, 16);
    chk("glitch_run", 32'(state), 32'd3);

    // Lock loss coinciding with SW_RESET: loss wins and is counted.
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("prec_wait", 32'(state), 32'd0);
    chk("prec_count", 32'(loss_count), 32'(2 * CNT_EN));
    run(1'b1, 15);

    // 17 losses: counter saturates, pulse still fires each time.
    npulse = 0;
    for (int k = 0; k < 17; k++) begin
      for (int i = 0; i < 3; i++) begin
        step(1'b0, 1'b0, 1'b0);
        npulse += int'(loss_pulse);
      end
      run(1'b1, 15);
    end
    chk("sat_count", 32'(loss_count), 32'(CNT_EN * CNT_MAX));
    chk("sat_pulses", 32'(npulse), 32'(17 * CNT_EN));
    chk("sat_run", 32'(state), 32'd3);

    // SW_RESET in RUN: one-cycle latency, READY again 12 edges later.
    step(1'b1, 1'b1, 1'b0);
    chk("sw_hold", 32'(state), 32'd1);
    chk("sw_core_hi", 32'(rst_core), 32'd1);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (i == 10) chk("sw_ready_lo", 32'(ready), 32'd0);
      if (i == 11) chk("sw_ready_hi", 32'(ready), 32'd1);
    end
    chk("sw_count", 32'(loss_count), 32'(CNT_EN * CNT_MAX));

    // RESET while in RELEASE.
    step(1'b1, 1'b1, 1'b0);
    run(1'b1, 8);
    chk("rr_release", 32'(state), 32'd2);
    step(1'b1, 1'b0, 1'b1);
    chk("rr_state", 32'(state), 32'd0);
    chk("rr_count", 32'(loss_count), 32'd0);
    chk("rr_core", 32'(rst_core), 32'd1);
    chk("rr_ro", 32'(rst_readout), 32'd1);
    chk("rr_ready", 32'(ready), 32'd0);

    // Random lock/SW_RESET/RESET traffic against the model.
    lk_r = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) lk_r = ~lk_r;
      step(lk_r, $urandom_range(0, 24) == 0, $urandom_range(0, 399) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
